// File: rtl/avr_pin_monitor.sv
// avr_pin_monitor
// Watches a bank of asynchronous AVR port pins, detects per-pin rising and
// falling edges, and queues timestamped events in a small FIFO for a
// valid/ready consumer. A free-running timestamp (gated by enable) also emits
// an entry whenever it wraps, so a consumer can reconstruct absolute time.
//
// Ports
//   clk, rst_n      : clock (rising edge) and asynchronous active-low reset
//   pins            : asynchronous pin levels, bit 0 = port pin 0
//   enable          : timestamp counting and event capture active
//   rise_en/fall_en : per-pin rising/falling edge capture enables
//   ev_valid/ready  : head-of-FIFO handshake
//   ev_pins/mask    : synchronised pin snapshot / pins that caused the entry
//   ev_wrap/ev_ts   : timestamp-wrap flag / timestamp of the head entry
//   fifo_level      : number of stored entries
//   ovf_clr         : pulse clearing drop_cnt and overflow
//   drop_cnt        : saturating count of entries dropped on a full FIFO
//   overflow        : sticky "something was dropped" flag
module avr_pin_monitor #(
    parameter int NPINS       = 8,
    parameter int TS_W        = 16,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NPINS-1:0]         pins,
    input  logic                     enable,
    input  logic [NPINS-1:0]         rise_en,
    input  logic [NPINS-1:0]         fall_en,
    input  logic                     ev_ready,
    output logic                     ev_valid,
    output logic [NPINS-1:0]         ev_pins,
    output logic [NPINS-1:0]         ev_mask,
    output logic                     ev_wrap,
    output logic [TS_W-1:0]          ev_ts,
    output logic [$clog2(DEPTH):0]   fifo_level,
    input  logic                     ovf_clr,
    output logic [7:0]               drop_cnt,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = 2 * NPINS + 1 + TS_W;
    localparam int ARM_W = $clog2(SYNC_STAGES + 2);

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [TS_W-1:0]  TS_ONE   = TS_W'(1);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);
    localparam logic [ARM_W-1:0] ARM_ONE  = ARM_W'(1);

    // State registers
    logic [SYNC_STAGES-1:0][NPINS-1:0] sync_q, sync_d;
    logic [NPINS-1:0]  prev_q, prev_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [ARM_W-1:0]  arm_q, arm_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic              overflow_q, overflow_d;
    logic              ev_valid_q, ev_valid_d;
    logic [ENT_W-1:0]  mem_q [DEPTH];

    // Combinational helpers
    logic [NPINS-1:0]  sync_s;
    logic [NPINS-1:0]  edge_s;
    logic [ENT_W-1:0]  entry_s;
    logic              wrap_s, push_s, pop_s, full_s, wr_s, drop_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Next-state logic: edge detection, timestamp, FIFO bookkeeping, drop counter
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pins};
        // prev follows sync even while disabled so that changes made while
        // capture is off never appear as edges after re-enabling
        prev_d = sync_s;

        // Hold off edge detection until the synchroniser and prev have
        // filled with real pin levels after reset
        if (arm_q == ARM_DONE) begin
            arm_d  = arm_q;
            edge_s = (sync_s & ~prev_q & rise_en) | (~sync_s & prev_q & fall_en);
        end else begin
            arm_d  = arm_q + ARM_ONE;
            edge_s = '0;
        end

        wrap_s  = enable & (&ts_q);
        push_s  = enable & ((|edge_s) | wrap_s);
        pop_s   = ev_valid_q & ev_ready;
        full_s  = (level_q == LVL_FULL);
        // A full FIFO still accepts a push when the head leaves in the same cycle
        wr_s    = push_s & (~full_s | pop_s);
        drop_s  = push_s & full_s & ~pop_s;
        entry_s = {sync_s, edge_s, wrap_s, ts_q};

        if (enable) begin
            ts_d = ts_q + TS_ONE;
        end else begin
            ts_d = ts_q;
        end

        if (wr_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // A clear coinciding with a drop leaves that drop recorded
        if (ovf_clr) begin
            drop_cnt_d = drop_s ? 8'd1 : 8'd0;
            overflow_d = drop_s;
        end else if (drop_s) begin
            drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;
            overflow_d = 1'b1;
        end else begin
            drop_cnt_d = drop_cnt_q;
            overflow_d = overflow_q;
        end

        // No bypass: a fresh entry becomes visible the cycle after it is stored
        ev_valid_d = (level_d != '0);
    end

    // Control and status registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            prev_q     <= '0;
            ts_q       <= '0;
            arm_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= 8'd0;
            overflow_q <= 1'b0;
            ev_valid_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            ts_q       <= ts_d;
            arm_q      <= arm_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
            ev_valid_q <= ev_valid_d;
        end
    end

    // Event storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_q[wr_ptr_q] <= entry_s;
        end
    end

    assign {ev_pins, ev_mask, ev_wrap, ev_ts} = mem_q[rd_ptr_q];
    assign ev_valid   = ev_valid_q;
    assign fifo_level = level_q;
    assign drop_cnt   = drop_cnt_q;
    assign overflow   = overflow_q;

endmodule
